// File: rtl/ysyx_24100005_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_24100005_ifu : instruction fetch unit in front of the single-cycle core
//
// Takes a fetch PC from the core, performs one word read from instruction
// memory (valid/ready request, valid-only response), and hands the result
// (instruction, PC, fault flag) back to the core over a valid/ready handshake.
// Only one fetch is ever outstanding. flush drops whatever is in flight.
//
// Optional build macro: IFU_TIMEOUT_EN
//   defined   : response-wait watchdog of TIMEOUT cycles in WAIT/DRAIN,
//               pulses mem_abort and reports a faulting fetch (WAIT) or
//               returns to IDLE (DRAIN).
//   undefined : no watchdog, mem_abort is constant 0.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   pc_valid/pc_ready/pc_in  fetch request from core (pc_ready combinational)
//   flush                    redirect, discards in-flight work
//   mem_req_*                read request to instruction memory
//   mem_resp_*               read response (single-cycle pulse)
//   mem_abort                cancel outstanding read (watchdog only)
//   inst_valid/inst_ready    instruction handshake to core
//   inst, inst_pc, inst_fault fetched word, its PC, fault flag
// ---------------------------------------------------------------------------
module ysyx_24100005_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_valid,
   input  logic [31:0] pc_in,
   output logic        pc_ready,
   input  logic        flush,
   output logic        mem_req_valid,
   output logic [31:0] mem_req_addr,
   input  logic        mem_req_ready,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   input  logic        mem_resp_err,
   output logic        mem_abort,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_fault,
   input  logic        inst_ready
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;

   logic [2:0]  r_state;
   logic        r_req_valid;
   logic [31:0] r_req_addr;
   logic        r_inst_valid;
   logic [31:0] r_inst;
   logic [31:0] r_inst_pc;
   logic        r_inst_fault;

   logic        w_pc_fire;
   logic        w_tmo_hit;     // watchdog expires this cycle
   logic        w_abort_pend;  // abort was pulsed last cycle while in WAIT

   assign pc_ready  = (r_state == S_IDLE) & ~flush;
   assign w_pc_fire = pc_valid & pc_ready;

`ifdef IFU_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   logic [CNT_W-1:0] r_cnt;
   logic             r_abort;
   logic             w_counting;

   // Counting stops (and the counter clears) outside WAIT/DRAIN, on a
   // response, and on the flush that moves WAIT into DRAIN, so every entry
   // to WAIT or DRAIN starts from zero.
   assign w_counting = (((r_state == S_WAIT) & ~r_abort & ~flush) |
                        (r_state == S_DRAIN)) & ~mem_resp_valid;
   assign w_tmo_hit    = w_counting & (r_cnt == CNT_W'(TIMEOUT - 1));
   assign w_abort_pend = r_abort;
   assign mem_abort    = r_abort;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt   <= '0;
         r_abort <= 1'b0;
      end else begin
         r_abort <= 1'b0;
         if (w_tmo_hit) begin
            r_cnt   <= '0;
            r_abort <= 1'b1;
         end else if (w_counting) begin
            r_cnt <= r_cnt + 1'b1;
         end else begin
            r_cnt <= '0;
         end
      end
   end
`else
   assign w_tmo_hit    = 1'b0;
   assign w_abort_pend = 1'b0;
   assign mem_abort    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_req_valid  <= 1'b0;
         r_req_addr   <= 32'h0;
         r_inst_valid <= 1'b0;
         r_inst       <= 32'h0;
         r_inst_pc    <= RESET_PC;
         r_inst_fault <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pc_fire) begin
                  r_inst_pc <= pc_in;
                  if (pc_in[1:0] != 2'b00) begin
                     // Misaligned: report a fault without touching memory.
                     r_inst       <= 32'h0;
                     r_inst_fault <= 1'b1;
                     r_inst_valid <= 1'b1;
                     r_state      <= S_HOLD;
                  end else begin
                     r_req_addr  <= pc_in;
                     r_req_valid <= 1'b1;
                     r_state     <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (flush) begin
                  // An accepted request still owes a response: drain it.
                  r_req_valid <= 1'b0;
                  r_state     <= mem_req_ready ? S_DRAIN : S_IDLE;
               end else if (mem_req_ready) begin
                  r_req_valid <= 1'b0;
                  r_state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (w_abort_pend) begin
                  // Memory will not answer after an abort.
                  if (flush) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_inst       <= 32'h0;
                     r_inst_fault <= 1'b1;
                     r_inst_valid <= 1'b1;
                     r_state      <= S_HOLD;
                  end
               end else if (flush) begin
                  r_state <= mem_resp_valid ? S_IDLE : S_DRAIN;
               end else if (mem_resp_valid) begin
                  r_inst       <= mem_resp_data;
                  r_inst_fault <= mem_resp_err;
                  r_inst_valid <= 1'b1;
                  r_state      <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (flush || inst_ready) begin
                  r_inst_valid <= 1'b0;
                  r_state      <= S_IDLE;
               end
            end
            S_DRAIN: begin
               if (mem_resp_valid || w_tmo_hit) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_req_valid  <= 1'b0;
               r_inst_valid <= 1'b0;
            end
         endcase
      end
   end

   assign mem_req_valid = r_req_valid;
   assign mem_req_addr  = r_req_addr;
   assign inst_valid    = r_inst_valid;
   assign inst          = r_inst;
   assign inst_pc       = r_inst_pc;
   assign inst_fault    = r_inst_fault;

endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
// Testbench for ysyx_24100005_ifu: cycle table of inputs/expected outputs,
// scoreboard of consumed instructions, plus hand-written random and
// watchdog sequences.
module tb_ysyx_24100005_ifu;

   localparam logic [31:0] P0 = 32'h8000_0000;
   localparam logic [31:0] A1 = 32'h8000_0010;
   localparam logic [31:0] A2 = 32'h8000_0020;
   localparam logic [31:0] A3 = 32'h8000_0030;
   localparam logic [31:0] A4 = 32'h8000_0040;
   localparam logic [31:0] A5 = 32'h8000_0050;
   localparam logic [31:0] A6 = 32'h8000_0060;
   localparam logic [31:0] A7 = 32'h8000_0070;
   localparam logic [31:0] A8 = 32'h8000_0080;
   localparam logic [31:0] A9 = 32'h8000_0200;
   localparam logic [31:0] M1 = 32'h8000_0081;
   localparam logic [31:0] M2 = 32'h8000_0002;
   localparam logic [31:0] I0 = 32'h0010_0093;
   localparam logic [31:0] I1 = 32'h0000_0013;
   localparam logic [31:0] I2 = 32'h0050_0113;
   localparam logic [31:0] I3 = 32'h0bad_c0de;
   localparam logic [31:0] DB = 32'hdead_beef;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pc_valid = 1'b0;
   logic [31:0] pc_in = 32'h0;
   logic        pc_ready;
   logic        flush = 1'b0;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready = 1'b0;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_resp_data = 32'h0;
   logic        mem_resp_err = 1'b0;
   logic        mem_abort;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_fault;
   logic        inst_ready = 1'b0;

   always #5 clk = ~clk;

   ysyx_24100005_ifu #(.RESET_PC(P0), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .pc_valid(pc_valid), .pc_in(pc_in), .pc_ready(pc_ready),
      .flush(flush),
      .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
      .mem_req_ready(mem_req_ready),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .mem_resp_err(mem_resp_err), .mem_abort(mem_abort),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
      .inst_fault(inst_fault), .inst_ready(inst_ready)
   );

   typedef struct {
      logic        rst_n, pcv;
      logic [31:0] pc;
      logic        fl, rqr, rsv;
      logic [31:0] rsd;
      logic        rse, ir, sb;
      logic        e_pcr, e_rqv;
      logic [31:0] e_addr;
      logic        e_iv;
      logic [31:0] e_inst, e_ipc;
      logic        e_flt;
   } vec_t;

   typedef struct {
      logic [31:0] ins;
      logic [31:0] pc;
      logic        flt;
   } sb_t;

   vec_t tbl[$];
   sb_t  sbq[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   n_req = 0;

   function automatic vec_t mk(
      input logic a_rst, a_pcv, input logic [31:0] a_pc,
      input logic a_fl, a_rqr, a_rsv, input logic [31:0] a_rsd,
      input logic a_rse, a_ir, a_sb,
      input logic b_pcr, b_rqv, input logic [31:0] b_addr,
      input logic b_iv, input logic [31:0] b_inst, b_ipc, input logic b_flt);
      vec_t v;
      v.rst_n = a_rst; v.pcv = a_pcv; v.pc = a_pc; v.fl = a_fl; v.rqr = a_rqr;
      v.rsv = a_rsv; v.rsd = a_rsd; v.rse = a_rse; v.ir = a_ir; v.sb = a_sb;
      v.e_pcr = b_pcr; v.e_rqv = b_rqv; v.e_addr = b_addr; v.e_iv = b_iv;
      v.e_inst = b_inst; v.e_ipc = b_ipc; v.e_flt = b_flt;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic sb_push(input logic [31:0] ins, input logic [31:0] pc, input logic flt);
      sb_t e;
      e.ins = ins; e.pc = pc; e.flt = flt;
      sbq.push_back(e);
   endtask

   // Consumes scoreboard entries on an inst handshake, then advances one clock.
   task automatic step();
      sb_t e;
      if (rst && inst_valid && inst_ready) begin
         if (sbq.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            e = sbq.pop_front();
            chk("sb_inst", inst, e.ins);
            chk("sb_pc", inst_pc, e.pc);
            chk("sb_fault", {31'd0, inst_fault}, {31'd0, e.flt});
         end
      end
      if (rst && mem_req_valid && mem_req_ready) n_req++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t        v;
      logic [31:0] last_pc;
      logic [31:0] pa;
      int          exp_req;
      last_pc = P0;
      exp_req = 8;

      //     rst pcv pc      fl rqr rsv rsd          rse ir sb  pcr rqv addr iv inst ipc flt
      tbl.push_back(mk(0,0,32'h0,   0,0,0,32'h0,       0,0,0,  1,0,32'h0,0,32'h0,P0,0));
      tbl.push_back(mk(1,1,P0,      0,1,0,32'h0,       0,0,0,  1,1,P0,0,32'h0,P0,0));
      tbl.push_back(mk(1,0,32'h0,   0,1,0,32'h0,       0,0,0,  0,0,P0,0,32'h0,P0,0));
      tbl.push_back(mk(1,0,32'h0,   0,0,1,I0,          0,0,1,  0,0,P0,1,I0,P0,0));
      tbl.push_back(mk(1,0,32'h0,   0,0,0,32'h0,       0,1,0,  0,0,P0,0,I0,P0,0));
      tbl.push_back(mk(1,1,A1,      0,0,0,32'h0,       0,0,0,  1,1,A1,0,I0,A1,0));
      for (int k = 0; k < 3; k++)
         tbl.push_back(mk(1,1,A1+4, 0,0,0,32'h0,       0,0,0,  0,1,A1,0,I0,A1,0));
      tbl.push_back(mk(1,0,32'h0,   0,1,0,32'h0,       0,0,0,  0,0,A1,0,I0,A1,0));
      tbl.push_back(mk(1,0,32'h0,   0,0,1,I1,          0,0,1,  0,0,A1,1,I1,A1,0));
      for (int k = 0; k < 4; k++)
         tbl.push_back(mk(1,1,A1+8, 0,0,0,32'h0,       0,0,0,  0,0,A1,1,I1,A1,0));
      tbl.push_back(mk(1,1,A1+8,    0,0,0,32'h0,       0,1,0,  0,0,A1,0,I1,A1,0));
      tbl.push_back(mk(1,1,M2,      0,0,0,32'h0,       0,0,1,  1,0,A1,1,32'h0,M2,1));
      tbl.push_back(mk(1,0,32'h0,   0,0,0,32'h0,       0,1,0,  0,0,A1,0,32'h0,M2,1));
      tbl.push_back(mk(1,1,A2,      0,1,0,32'h0,       0,0,0,  1,1,A2,0,32'h0,A2,1));
      tbl.push_back(mk(1,0,32'h0,   0,1,0,32'h0,       0,0,0,  0,0,A2,0,32'h0,A2,1));
      tbl.push_back(mk(1,0,32'h0,   1,0,0,32'h0,       0,0,0,  0,0,A2,0,32'h0,A2,1));
      tbl.push_back(mk(1,1,A3,      0,0,0,32'h0,       0,0,0,  0,0,A2,0,32'h0,A2,1));
      tbl.push_back(mk(1,1,A3,      0,0,1,DB,          0,0,0,  0,0,A2,0,32'h0,A2,1));
      tbl.push_back(mk(1,1,A3,      0,1,0,32'h0,       0,0,0,  1,1,A3,0,32'h0,A3,1));
      tbl.push_back(mk(1,0,32'h0,   0,1,0,32'h0,       0,0,0,  0,0,A3,0,32'h0,A3,1));
      tbl.push_back(mk(1,0,32'h0,   0,0,1,I2,          0,0,1,  0,0,A3,1,I2,A3,0));
      tbl.push_back(mk(1,0,32'h0,   0,0,0,32'h0,       0,1,0,  0,0,A3,0,I2,A3,0));
      tbl.push_back(mk(1,1,A4,      0,1,0,32'h0,       0,0,0,  1,1,A4,0,I2,A4,0));
      tbl.push_back(mk(1,0,32'h0,   0,1,0,32'h0,       0,0,0,  0,0,A4,0,I2,A4,0));
      tbl.push_back(mk(1,0,32'h0,   0,0,1,I3,          1,0,1,  0,0,A4,1,I3,A4,1));
      tbl.push_back(mk(1,0,32'h0,   0,0,0,32'h0,       0,1,0,  0,0,A4,0,I3,A4,1));
      tbl.push_back(mk(1,1,A5,      0,1,0,32'h0,       0,0,0,  1,1,A5,0,I3,A5,1));
      tbl.push_back(mk(1,0,32'h0,   0,1,0,32'h0,       0,0,0,  0,0,A5,0,I3,A5,1));
      tbl.push_back(mk(0,0,32'h0,   0,0,0,32'h0,       0,0,0,  0,0,32'h0,0,32'h0,P0,0));
      tbl.push_back(mk(1,0,32'h0,   0,0,1,32'h1234_5678,0,0,0, 1,0,32'h0,0,32'h0,P0,0));
      tbl.push_back(mk(1,1,A6,      0,0,0,32'h0,       0,0,0,  1,1,A6,0,32'h0,A6,0));
      tbl.push_back(mk(1,0,32'h0,   1,0,0,32'h0,       0,0,0,  0,0,A6,0,32'h0,A6,0));
      tbl.push_back(mk(1,1,A7,      1,0,0,32'h0,       0,0,0,  0,0,A6,0,32'h0,A6,0));
      tbl.push_back(mk(1,1,A7,      0,1,0,32'h0,       0,0,0,  1,1,A7,0,32'h0,A7,0));
      tbl.push_back(mk(1,0,32'h0,   1,1,0,32'h0,       0,0,0,  0,0,A7,0,32'h0,A7,0));
      tbl.push_back(mk(1,0,32'h0,   0,0,1,DB,          0,0,0,  0,0,A7,0,32'h0,A7,0));
      tbl.push_back(mk(1,1,A8,      0,1,0,32'h0,       0,0,0,  1,1,A8,0,32'h0,A8,0));
      tbl.push_back(mk(1,0,32'h0,   0,1,0,32'h0,       0,0,0,  0,0,A8,0,32'h0,A8,0));
      tbl.push_back(mk(1,0,32'h0,   1,0,1,32'hcafe_f00d,0,0,0, 0,0,A8,0,32'h0,A8,0));
      tbl.push_back(mk(1,1,M1,      0,0,0,32'h0,       0,0,0,  1,0,A8,1,32'h0,M1,1));
      tbl.push_back(mk(1,0,32'h0,   1,0,0,32'h0,       0,0,0,  0,0,A8,0,32'h0,M1,1));
      tbl.push_back(mk(1,0,32'h0,   0,0,0,32'h0,       0,0,0,  1,0,A8,0,32'h0,M1,1));

      // First reset cycle; the table's first row is the second one.
      @(posedge clk);
      #1;

      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         rst = v.rst_n; pc_valid = v.pcv; pc_in = v.pc; flush = v.fl;
         mem_req_ready = v.rqr; mem_resp_valid = v.rsv; mem_resp_data = v.rsd;
         mem_resp_err = v.rse; inst_ready = v.ir;
         #1;
         chk($sformatf("r%0d_pc_ready", i), {31'd0, pc_ready}, {31'd0, v.e_pcr});
         if (v.pcv && v.e_pcr) last_pc = v.pc;
         if (v.sb) begin
            if (v.pcv) sb_push(32'h0, v.pc, 1'b1);
            else       sb_push(v.rsd, last_pc, v.rse);
         end
         step();
         chk($sformatf("r%0d_req_valid", i), {31'd0, mem_req_valid}, {31'd0, v.e_rqv});
         chk($sformatf("r%0d_req_addr", i), mem_req_addr, v.e_addr);
         chk($sformatf("r%0d_inst_valid", i), {31'd0, inst_valid}, {31'd0, v.e_iv});
         chk($sformatf("r%0d_inst", i), inst, v.e_inst);
         chk($sformatf("r%0d_inst_pc", i), inst_pc, v.e_ipc);
         chk($sformatf("r%0d_inst_fault", i), {31'd0, inst_fault}, {31'd0, v.e_flt});
         chk($sformatf("r%0d_abort", i), {31'd0, mem_abort}, 32'd0);
         $display("row %0d pc_ready=%0b req=%0b addr=%h iv=%0b inst=%h pc=%h flt=%0b",
                  i, pc_ready, mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc, inst_fault);
      end
      rst = 1'b1; pc_valid = 0; flush = 0; mem_req_ready = 0;
      mem_resp_valid = 0; mem_resp_err = 0; inst_ready = 0;

      // Back-to-back fetches with random request stall and response latency.
      for (int n = 0; n < 4; n++) begin
         int st;
         int lt;
         pa = 32'h8000_0100 + 32'(n * 4);
         pc_valid = 1; pc_in = pa;
         #1;
         chk("rnd_pc_ready", {31'd0, pc_ready}, 32'd1);
         step();
         pc_valid = 0;
         chk("rnd_req_addr", mem_req_addr, pa);
         st = $urandom_range(0, 2);
         for (int k = 0; k < st; k++) begin
            step();
            chk("rnd_req_hold", {mem_req_valid, mem_req_addr[30:0]}, {1'b1, pa[30:0]});
         end
         mem_req_ready = 1;
         step();
         mem_req_ready = 0;
         chk("rnd_req_drop", {31'd0, mem_req_valid}, 32'd0);
         lt = $urandom_range(0, 2);
         for (int k = 0; k < lt; k++) begin
            step();
            chk("rnd_wait_iv", {31'd0, inst_valid}, 32'd0);
         end
         mem_resp_valid = 1; mem_resp_data = pa ^ 32'h0000_0013;
         sb_push(pa ^ 32'h0000_0013, pa, 1'b0);
         step();
         mem_resp_valid = 0;
         chk("rnd_iv", {31'd0, inst_valid}, 32'd1);
         inst_ready = 1;
         step();
         inst_ready = 0;
         chk("rnd_iv_drop", {31'd0, inst_valid}, 32'd0);
         $display("rnd fetch %0d pc=%h stall=%0d lat=%0d", n, pa, st, lt);
      end
      exp_req += 4;

`ifdef IFU_TIMEOUT_EN
      // No response: abort pulses 4 cycles after entering WAIT, fault next cycle.
      pc_valid = 1; pc_in = A9; mem_req_ready = 1;
      step();
      pc_valid = 0;
      step();
      mem_req_ready = 0;
      exp_req += 1;
      for (int k = 1; k <= 4; k++) begin
         step();
         chk($sformatf("tmo_abort_%0d", k), {31'd0, mem_abort}, (k == 4) ? 32'd1 : 32'd0);
         chk($sformatf("tmo_iv_%0d", k), {31'd0, inst_valid}, 32'd0);
      end
      step();
      chk("tmo_abort_off", {31'd0, mem_abort}, 32'd0);
      chk("tmo_iv", {31'd0, inst_valid}, 32'd1);
      chk("tmo_fault", {31'd0, inst_fault}, 32'd1);
      chk("tmo_inst", inst, 32'h0);
      chk("tmo_pc", inst_pc, A9);
      sb_push(32'h0, A9, 1'b1);
      inst_ready = 1;
      step();
      inst_ready = 0;
      $display("timeout fetch pc=%h done", A9);
`endif

      chk("req_count", 32'(n_req), 32'(exp_req));
      chk("sb_empty", 32'(sbq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/ysyx_24100005_ifu.md
Name: ysyx_24100005_ifu

Overview:
Instruction fetch unit that sits directly upstream of the single-cycle core top.
- Accepts a fetch PC from the core, issues one word read to instruction memory over a valid/ready request and a valid-only response.
- Presents the fetched instruction, its PC and a fault flag to the core over a valid/ready handshake.
- Supports exactly one outstanding fetch. A flush (redirect) input discards in-flight work.

Parameters:
- RESET_PC, 32'h8000_0000, reset value of inst_pc.
- TIMEOUT, 16, response-wait limit in cycles; used only when IFU_TIMEOUT_EN is defined.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset (0 = reset, sampled at posedge clk).
- pc_valid  input  1  core requests a fetch at pc_in.
- pc_in  input  32  fetch address.
- pc_ready  output  1  IFU accepts a PC; combinational = (state==IDLE) & ~flush.
- flush  input  1  redirect: drop pending fetch or held instruction.
- mem_req_valid  output  1  instruction memory read request.
- mem_req_addr  output  32  word address; stable while mem_req_valid=1.
- mem_req_ready  input  1  memory accepts request.
- mem_resp_valid  input  1  read data valid (single-cycle pulse).
- mem_resp_data  input  32  read data.
- mem_resp_err  input  1  bus error with the response.
- mem_abort  output  1  one-cycle pulse telling memory to cancel the outstanding read (timeout only).
- inst_valid  output  1  instruction available.
- inst  output  32  instruction word.
- inst_pc  output  32  PC of inst.
- inst_fault  output  1  misaligned PC, bus error or timeout.
- inst_ready  input  1  core consumes instruction.

Behaviour:
- Reset (rst=0 at posedge) has priority over everything:
  - state=IDLE.
  - mem_req_valid=0, mem_req_addr=0, mem_abort=0.
  - inst_valid=0, inst=0, inst_pc=RESET_PC, inst_fault=0.
  - Timeout counter=0.
  - A response arriving during or after reset is ignored.
- All outputs except pc_ready are registered.
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
- IDLE, on pc_valid & pc_ready:
  - If pc_in[1:0]≠0: no memory request. Go to HOLD next cycle with inst=0, inst_pc=pc_in, inst_fault=1, inst_valid=1.
  - Otherwise: mem_req_addr=pc_in, inst_pc=pc_in, mem_req_valid=1, go to REQ.
- REQ:
  - mem_req_valid and mem_req_addr are held until mem_req_valid & mem_req_ready.
  - On that handshake, mem_req_valid=0 next cycle and state goes to WAIT.
  - Memory never responds in the same cycle as request acceptance.
- WAIT:
  - On mem_resp_valid: inst=mem_resp_data, inst_fault=mem_resp_err, inst_valid=1, go to HOLD.
- HOLD:
  - inst, inst_pc and inst_fault stay stable while inst_valid=1.
  - On inst_valid & inst_ready: inst_valid=0 next cycle, go to IDLE.
  - inst_valid never drops without a handshake, except on flush or reset.
- Latency:
  - PC handshake at cycle 0 gives mem_req_valid at cycle 1.
  - With mem_req_ready=1 at cycle 1 and the response at cycle 2, inst_valid is 1 at cycle 3.
  - A new PC can be accepted in the cycle after the inst handshake.
- Flush (priority below reset only). The PC offered in the flush cycle is never accepted.
  - IDLE: no effect.
  - HOLD: inst_valid=0, go to IDLE.
  - REQ without request handshake: mem_req_valid=0, go to IDLE.
  - REQ with request handshake in the same cycle: mem_req_valid=0, go to DRAIN.
  - WAIT without mem_resp_valid: go to DRAIN.
  - WAIT with mem_resp_valid in the same cycle: data discarded, go to IDLE.
  - DRAIN: pc_ready=0; on mem_resp_valid, discard the data and go to IDLE. A flush while already in DRAIN stays in DRAIN.
- Outstanding limit: at most one accepted memory request without its response; never issue while WAIT or DRAIN.

Optional Feature:
IFU_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT or DRAIN and increments each cycle without mem_resp_valid.
  - On reaching TIMEOUT, mem_abort pulses for one cycle and the counter clears.
  - Timeout in WAIT: go to HOLD with inst=0, inst_fault=1, inst_valid=1.
  - Timeout in DRAIN: go to IDLE.
  - Memory guarantees no response after mem_abort.
- Undefined:
  - No counter; WAIT and DRAIN wait indefinitely.
  - mem_abort is tied to 0; the port is still present.

Test Plan:
- Reset then fetch: rst=0 for 2 cycles, then pc_in=32'h8000_0000 with pc_valid=1, mem_req_ready=1, response 32'h0010_0093 one cycle after acceptance.
  -> inst_valid=1 at cycle 3, inst=32'h0010_0093, inst_pc=32'h8000_0000, inst_fault=0.
- Back-pressure: mem_req_ready low for 3 cycles, inst_ready low for 4 cycles.
  -> mem_req_addr stable during the stall, inst stable during the hold, exactly one request, no new pc_ready until the inst handshake.
- Misaligned PC: pc_in=32'h8000_0002.
  -> No mem_req_valid; next cycle inst_valid=1, inst_fault=1, inst=0, inst_pc=32'h8000_0002.
- Flush in WAIT: flush, then response 32'hdead_beef two cycles later.
  -> State goes to DRAIN, pc_ready=0 until the response, data never appears on inst, next fetch proceeds normally.
- Bus error: response with mem_resp_err=1.
  -> inst_fault=1 with inst_valid; a mid-WAIT rst=0 clears all outputs, and a response in the next cycle is ignored.
- IFU_TIMEOUT_EN, TIMEOUT=4, no response.
  -> mem_abort pulses once 4 cycles after entering WAIT; inst_valid=1, inst_fault=1 next cycle.
